// File: rtl/frogger_pkg.sv
// Shared types for the frog keyboard path: move directions, HID codes and the keycode decoder.
package frogger_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  // A decoded key: valid=0 stands for NONE.
  typedef struct packed {
    logic valid;
    dir_t dir;
  } key_t;

  localparam logic [7:0] HID_W = 8'h1A;
  localparam logic [7:0] HID_A = 8'h04;
  localparam logic [7:0] HID_S = 8'h16;
  localparam logic [7:0] HID_D = 8'h07;

  function automatic key_t decode_byte(input logic [7:0] code);
    key_t k;
    k.valid = 1'b1;
    k.dir   = UP;
    case (code)
      HID_W:   k.dir = UP;
      HID_S:   k.dir = DOWN;
      HID_A:   k.dir = LEFT;
      HID_D:   k.dir = RIGHT;
      default: k.valid = 1'b0;
    endcase
    return k;
  endfunction

  // Primary byte wins; secondary is consulted only when the primary is not a direction.
  function automatic key_t decode_keycode(input logic [15:0] kc);
    key_t p;
    p = decode_byte(kc[7:0]);
    return p.valid ? p : decode_byte(kc[15:8]);
  endfunction

endpackage

// File: rtl/keyq_fifo.sv
// First-word-fall-through FIFO for move commands; head is forced to zero while empty.
module keyq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_din,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_dout_c,
  output logic                         o_full_c,
  output logic                         o_empty_c,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_count   = r_count;
  assign o_empty_c = (r_count == '0);
  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_dout_c  = o_empty_c ? '0 : r_mem[r_rptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_do_pop  = i_pop && !o_empty_c;
  assign w_do_push = i_push && (!o_full_c || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/keycode_move_queue.sv
// Converts HID keycodes into queued frog move commands. Define KEYQ_TYPEMATIC_EN to enable
// frame-paced key repeat; without it each press yields exactly one command.
module keycode_move_queue
  import frogger_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned REPEAT_DELAY  = 20,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [15:0]                keycode,
  input  logic                       frame_clk,
  input  logic                       move_ready,
  output logic                       move_valid,
  output logic [1:0]                 move_dir,
  output logic                       overflow,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  logic r_fs_meta;
  logic r_fs_sync;
  logic r_fs_prev;
  logic w_tick;
  key_t w_key;
  key_t r_held;
  logic w_press;
  logic w_rep;
  logic w_push;
  dir_t w_push_dir;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic r_overflow;

  // Frame strobe: synchronise vsync and pulse on its falling edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fs_meta <= 1'b1;
      r_fs_sync <= 1'b1;
      r_fs_prev <= 1'b1;
    end else begin
      r_fs_meta <= frame_clk;
      r_fs_sync <= r_fs_meta;
      r_fs_prev <= r_fs_sync;
    end
  end

  assign w_tick  = r_fs_prev && !r_fs_sync;
  assign w_key   = decode_keycode(keycode);
  assign w_press = w_key.valid && (!r_held.valid || (r_held.dir != w_key.dir));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_held <= '0;
    end else begin
      r_held <= w_key;
    end
  end

`ifdef KEYQ_TYPEMATIC_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCNT_W  = $clog2(REP_MAX + 1);

  rep_state_t        r_state;
  logic [RCNT_W-1:0] r_cnt;

  // Repeat fires on the tick that completes the current interval, unless a press supersedes it.
  assign w_rep = w_tick && !w_press && w_key.valid &&
                 (((r_state == ST_DELAY)  && (r_cnt == RCNT_W'(REPEAT_DELAY - 1))) ||
                  ((r_state == ST_REPEAT) && (r_cnt == RCNT_W'(REPEAT_PERIOD - 1))));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (w_press) begin
      r_state <= ST_DELAY;
      r_cnt   <= '0;
    end else if (!w_key.valid) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (w_tick) begin
      case (r_state)
        ST_DELAY: begin
          if (w_rep) begin
            r_state <= ST_REPEAT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + RCNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (w_rep) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + RCNT_W'(1);
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end
`else
  logic w_unused_tick;

  assign w_rep         = 1'b0;
  assign w_unused_tick = w_tick;
`endif

  assign w_push     = w_press || w_rep;
  assign w_push_dir = w_press ? w_key.dir : r_held.dir;
  assign w_pop      = move_valid && move_ready;

  keyq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_fifo (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .i_push    (w_push),
    .i_din     (w_push_dir),
    .i_pop     (w_pop),
    .o_dout_c  (move_dir),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_count   (q_count)
  );

  assign move_valid = !w_empty;

  // Sticky drop flag: push into a full queue with no pop to make room.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;

endmodule

// File: tb/tb_keycode_move_queue.sv
// Bench for keycode_move_queue: directed vector table, reset/typematic sequences, random vs model.
module tb_keycode_move_queue;

  localparam int DEPTH = 4;

`ifdef KEYQ_TYPEMATIC_EN
  localparam bit TM = 1'b1;
`else
  localparam bit TM = 1'b0;
`endif

  logic        Clk;
  logic        Reset_n;
  logic [15:0] keycode;
  logic        frame_clk;
  logic        move_ready;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        overflow;
  logic [2:0]  q_count;

  int n_checks = 0;
  int n_errors = 0;

  keycode_move_queue #(
    .DEPTH         (DEPTH),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (8)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .keycode    (keycode),
    .frame_clk  (frame_clk),
    .move_ready (move_ready),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .overflow   (overflow),
    .q_count    (q_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] kc;
    logic        rdy;
    logic        v;
    logic [1:0]  d;
    int          c;
    logic        o;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n    = 1'b0;
    keycode    = 16'h0000;
    move_ready = 1'b0;
    frame_clk  = 1'b1;
    repeat (2) @(posedge Clk);
    #2;
    Reset_n = 1'b1;
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      frame_clk = 1'b0;
      repeat (3) step();
      frame_clk = 1'b1;
      repeat (3) step();
    end
  endtask

  // Reference decode written straight from the key mapping: -1 means no direction.
  function automatic int ref_byte(input logic [7:0] b);
    case (b)
      8'h1A:   return 0;
      8'h16:   return 1;
      8'h04:   return 2;
      8'h07:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int ref_decode(input logic [15:0] kc);
    int p;
    p = ref_byte(kc[7:0]);
    return (p >= 0) ? p : ref_byte(kc[15:8]);
  endfunction

  int          m_q[$];
  int          m_held;
  bit          m_ovf;
  logic [15:0] pool [12];

  initial begin
    vecs[0]  = '{16'h0000, 1'b0, 1'b0, 2'd0, 0, 1'b0};
    vecs[1]  = '{16'h001A, 1'b0, 1'b1, 2'd0, 1, 1'b0};
    vecs[2]  = '{16'h001A, 1'b0, 1'b1, 2'd0, 1, 1'b0};
    vecs[3]  = '{16'h0004, 1'b0, 1'b1, 2'd0, 2, 1'b0};
    vecs[4]  = '{16'h0007, 1'b0, 1'b1, 2'd0, 3, 1'b0};
    vecs[5]  = '{16'h0000, 1'b0, 1'b1, 2'd0, 3, 1'b0};
    vecs[6]  = '{16'h1600, 1'b0, 1'b1, 2'd0, 4, 1'b0};
    vecs[7]  = '{16'h001A, 1'b0, 1'b1, 2'd0, 4, 1'b1};
    vecs[8]  = '{16'h0000, 1'b1, 1'b1, 2'd2, 3, 1'b1};
    vecs[9]  = '{16'h0016, 1'b0, 1'b1, 2'd2, 4, 1'b1};
    vecs[10] = '{16'h0004, 1'b1, 1'b1, 2'd3, 4, 1'b1};
    vecs[11] = '{16'h0004, 1'b1, 1'b1, 2'd1, 3, 1'b1};
    vecs[12] = '{16'h0000, 1'b1, 1'b1, 2'd1, 2, 1'b1};
    vecs[13] = '{16'h0000, 1'b1, 1'b1, 2'd2, 1, 1'b1};
    vecs[14] = '{16'h0000, 1'b1, 1'b0, 2'd0, 0, 1'b1};
    vecs[15] = '{16'h0000, 1'b1, 1'b0, 2'd0, 0, 1'b1};
    vecs[16] = '{16'h071A, 1'b1, 1'b1, 2'd0, 1, 1'b1};
    vecs[17] = '{16'h071A, 1'b1, 1'b0, 2'd0, 0, 1'b1};
    vecs[18] = '{16'h0700, 1'b1, 1'b1, 2'd3, 1, 1'b1};
    vecs[19] = '{16'h0700, 1'b1, 1'b0, 2'd0, 0, 1'b1};
    vecs[20] = '{16'h0505, 1'b0, 1'b0, 2'd0, 0, 1'b1};
    vecs[21] = '{16'h1A07, 1'b0, 1'b1, 2'd3, 1, 1'b1};

    pool[0] = 16'h0000; pool[1] = 16'h001A; pool[2]  = 16'h0016; pool[3]  = 16'h0004;
    pool[4] = 16'h0007; pool[5] = 16'h1A00; pool[6]  = 16'h0700; pool[7]  = 16'h071A;
    pool[8] = 16'h1604; pool[9] = 16'h0505; pool[10] = 16'h33FF; pool[11] = 16'h0000;

    // Directed vectors, one clock per row, starting from reset.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      if (i == 3) begin
        keycode    = 16'h001A;
        move_ready = 1'b0;
        repeat (100) step();
        check("hold_no_repeat_count", int'(q_count), 1);
      end
      keycode    = vecs[i].kc;
      move_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_valid", i), int'(move_valid), int'(vecs[i].v));
      check($sformatf("vec%0d_dir", i),   int'(move_dir),   int'(vecs[i].d));
      check($sformatf("vec%0d_count", i), int'(q_count),    vecs[i].c);
      check($sformatf("vec%0d_ovf", i),   int'(overflow),   int'(vecs[i].o));
    end

    // Asynchronous reset with three commands queued and overflow set.
    move_ready = 1'b0;
    keycode = 16'h001A; step();
    keycode = 16'h0004; step();
    check("pre_reset_count", int'(q_count), 3);
    check("pre_reset_ovf", int'(overflow), 1);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_rst_valid", int'(move_valid), 0);
    check("async_rst_dir",   int'(move_dir),   0);
    check("async_rst_count", int'(q_count),    0);
    check("async_rst_ovf",   int'(overflow),   0);
    @(posedge Clk);
    #2;
    Reset_n = 1'b1;

    // Held key over frame ticks.
    do_reset();
    keycode = 16'h001A;
    repeat (2) step();
    check("tm_press_count", int'(q_count), 1);
    run_frames(19);
    repeat (4) step();
    check("tm_19_count", int'(q_count), 1);
    run_frames(1);
    repeat (4) step();
    check("tm_20_count", int'(q_count), TM ? 2 : 1);
    run_frames(16);
    repeat (4) step();
    check("tm_36_count", int'(q_count), TM ? 4 : 1);
    check("tm_36_ovf", int'(overflow), 0);
    check("tm_36_dir", int'(move_dir), 0);

    // Release after 30 frames stops further repeats.
    do_reset();
    keycode = 16'h001A;
    repeat (2) step();
    run_frames(30);
    keycode = 16'h0000;
    run_frames(6);
    repeat (4) step();
    check("tm_release_count", int'(q_count), TM ? 3 : 1);

    // Random traffic against a queue model; no frame ticks occur here.
    do_reset();
    m_q.delete();
    m_held = -1;
    m_ovf  = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int  dec;
      bit  pop;
      if ($urandom_range(3) == 0) begin
        keycode = ($urandom_range(7) == 0) ? 16'($urandom) : pool[$urandom_range(11)];
      end
      move_ready = ($urandom_range(2) == 0);
      dec = ref_decode(keycode);
      pop = (m_q.size() > 0) && move_ready;
      if (pop) void'(m_q.pop_front());
      if (dec >= 0 && dec != m_held) begin
        if (m_q.size() < DEPTH) m_q.push_back(dec);
        else m_ovf = 1'b1;
      end
      m_held = dec;
      step();
      check("rnd_valid", int'(move_valid), (m_q.size() > 0) ? 1 : 0);
      check("rnd_dir",   int'(move_dir),   (m_q.size() > 0) ? m_q[0] : 0);
      check("rnd_count", int'(q_count),    m_q.size());
      check("rnd_ovf",   int'(overflow),   int'(m_ovf));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
